featuremap_accum_stream: RTL and testbench
==========================================

FEATUREMAP_ACCUM_STREAM -- requirements
Module: featuremap_accum_stream

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of every channel sample and of data_out (signed two's-complement fixed point).
REQ-002 Parameter NUM_CH, 16, number of input channels summed (legal 1..32).
REQ-003 Parameter BIAS, 0, signed DATA_WIDTH bias added once per output pixel.
REQ-004 Parameter RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass signed result.
REQ-005 Parameter WIDTH, 56, output pixels per row; HEIGHT, 56, rows per frame.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 data_in  input  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]; show-ahead FIFO data.
REQ-009 data_fifo_empty  input  NUM_CH  per-channel FIFO empty flag.
REQ-010 rdreq  output  1  common read request to all channel FIFOs.
REQ-011 ready_in  input  1  downstream can accept data_out this cycle.
REQ-012 data_out  output  DATA_WIDTH  accumulated, biased, saturated, optionally ReLU'd pixel.
REQ-013 valid_out  output  1  data_out valid.
REQ-014 frame_done  output  1  one-cycle pulse after last pixel of a frame transferred.
REQ-015 overflow  output  1  sticky flag, set on any saturation event.

Function
REQ-016 Pipeline enable en SHALL equal !(valid_out && !ready_in); all pipeline registers, counters and valid bits SHALL hold when en=0.
REQ-017 rdreq SHALL equal en AND no bit of data_fifo_empty set; data_in is captured into stage 0 in the same cycle rdreq=1.
REQ-018 Summation SHALL be a registered binary adder tree of L=ceil(log2(NUM_CH)) levels (L=0 for NUM_CH=1), each level a pipeline stage carrying a valid bit.
REQ-019 Internal sum width SHALL be DATA_WIDTH+L+1 bits, sign-extended; no intermediate truncation.
REQ-020 Final stage SHALL add sign-extended BIAS, saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then apply ReLU if RELU_EN=1, registering data_out.
REQ-021 Latency from rdreq=1 to corresponding valid_out=1 SHALL be exactly L+1 cycles when en stays 1 (5 cycles for NUM_CH=16).
REQ-022 Throughput SHALL be one pixel per cycle with all FIFOs non-empty and ready_in=1; bubbles SHALL propagate as valid=0 stages.
REQ-023 While valid_out=1 and ready_in=0, data_out SHALL remain stable and rdreq SHALL be 0.
REQ-024 overflow SHALL set on the cycle a saturated value is registered into data_out and clear only by reset.
REQ-025 Column counter 0..WIDTH-1 and row counter 0..HEIGHT-1 SHALL advance on each valid_out&&ready_in handshake; column wraps to 0 and increments row; row wraps to 0 after HEIGHT-1.
REQ-026 frame_done SHALL pulse high for exactly one cycle, the cycle after the handshake at column WIDTH-1, row HEIGHT-1.
REQ-027 Simultaneous FIFO non-empty and downstream stall: stall wins, no read occurs, no sample is lost or duplicated.

Reset
REQ-028 On rst=0, asynchronously: all stage valid bits, valid_out, frame_done, overflow, counters = 0; data_out = 0; rdreq = 0.
REQ-029 Reset mid-frame SHALL discard all in-flight pixels; after release the next output is column 0, row 0.
REQ-030 rdreq SHALL not assert before the first rising edge following rst deassertion.

Verification
REQ-031 NUM_CH=16, FRAC 16 scaling, all channels 0x00010000, BIAS=0x00008000 -> data_out=0x00108000, valid_out exactly 5 cycles after rdreq.
REQ-032 All channels 0xFFFF0000 (-1.0), BIAS=0, RELU_EN=1 -> data_out=0x00000000; RELU_EN=0 -> 0xFFF00000; overflow stays 0.
REQ-033 All channels 0x7FFFFFFF, BIAS=0 -> data_out=0x7FFFFFFF, overflow=1 and remains 1 after later in-range pixels.
REQ-034 Stream 10 ascending pixels, hold ready_in=0 for 3 cycles mid-stream -> rdreq=0 during stall, all 10 outputs in order, none lost or duplicated.
REQ-035 WIDTH=4, HEIGHT=2, 8 pixels streamed -> frame_done single pulse one cycle after 8th handshake; 9th pixel reported as column 0, row 0.
REQ-036 Assert rst=0 with 3 pixels in flight -> valid_out, overflow, counters 0 immediately; no stale pixel emerges after release.

Source files
------------

// File: rtl/featuremap_accum_stream.sv
// rtl/featuremap_accum_stream.sv - multi-channel feature map accumulator with bias, saturation, ReLU
// Pipelined adder tree over show-ahead channel FIFOs, with frame position tracking.
module featuremap_accum_stream #(
  parameter int                           DATA_WIDTH = 32,
  parameter int                           NUM_CH     = 16,
  parameter logic signed [DATA_WIDTH-1:0] BIAS       = '0,
  parameter bit                           RELU_EN    = 1'b1,
  parameter int                           WIDTH      = 56,
  parameter int                           HEIGHT     = 56
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            data_fifo_empty,
  output logic                         rdreq,
  input  logic                         ready_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam int L  = (NUM_CH <= 1) ? 0 : $clog2(NUM_CH);
  localparam int P  = 1 << L;
  localparam int SW = DATA_WIDTH + L + 1;
  localparam int NN = 2 * P - 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic signed [SW-1:0] MAX_V = SW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

  // Tree nodes stored level by level: level k starts at 2P - (2P >> k), root is the last entry.
  logic signed [SW-1:0] node [NN];
  logic [L:0]           vld;
  logic                 started;
  logic                 en;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;

  assign en    = !(valid_out && !ready_in);
  assign rdreq = started && en && !(|data_fifo_empty);

  // Holds off reads until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) started <= 1'b0;
    else      started <= 1'b1;
  end

  for (genvar c = 0; c < P; c++) begin : g_leaf
    if (c < NUM_CH) begin : g_ch
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       node[c] <= '0;
        else if (rdreq) node[c] <= SW'($signed(data_in[c*DATA_WIDTH +: DATA_WIDTH]));
      end
    end else begin : g_pad
      assign node[c] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    vld[0] <= 1'b0;
    else if (en) vld[0] <= rdreq;
  end

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int OI = 2 * P - ((2 * P) >> (k - 1));
    localparam int OO = 2 * P - ((2 * P) >> k);
    for (genvar i = 0; i < (P >> k); i++) begin : g_add
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    node[OO+i] <= '0;
        else if (en) node[OO+i] <= node[OI+2*i] + node[OI+2*i+1];
      end
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)    vld[k] <= 1'b0;
      else if (en) vld[k] <= vld[k-1];
    end
  end

  logic signed [SW-1:0]  biased;
  logic                  sat;
  logic [DATA_WIDTH-1:0] result;

  // The extra sum bit guarantees the bias add cannot wrap before saturation.
  always_comb begin
    biased = node[NN-1] + SW'(BIAS);
    sat    = 1'b0;
    result = biased[DATA_WIDTH-1:0];
    if (biased > MAX_V) begin
      sat    = 1'b1;
      result = MAX_V[DATA_WIDTH-1:0];
    end else if (biased < MIN_V) begin
      sat    = 1'b1;
      result = MIN_V[DATA_WIDTH-1:0];
    end
    if (RELU_EN && result[DATA_WIDTH-1]) result = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      overflow  <= 1'b0;
    end else if (en) begin
      valid_out <= vld[L];
      if (vld[L]) begin
        data_out <= result;
        if (sat) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (valid_out && ready_in) begin
        if (col == COL_LAST) begin
          col        <= '0;
          row        <= (row == ROW_LAST) ? '0 : row + 1'b1;
          frame_done <= (row == ROW_LAST);
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_featuremap_accum_stream.sv
// tb/tb_featuremap_accum_stream.sv - directed bench for featuremap_accum_stream
// Two instances share stimulus: one biased with ReLU, one unbiased pass-through.
module tb_featuremap_accum_stream;

  localparam int NCH = 16;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    empty;
  logic              ready_in;
  logic              rdreq_a, valid_a, fd_a, ovf_a;
  logic              rdreq_b, valid_b, fd_b, ovf_b;
  logic [DW-1:0]     data_a, data_b;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] ch;
    logic        ramp;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        ovf;
  } vec_t;

  vec_t tbl [8];

  featuremap_accum_stream #(.DATA_WIDTH(DW), .NUM_CH(NCH), .BIAS(32'h00008000), .RELU_EN(1'b1),
                            .WIDTH(4), .HEIGHT(2)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .data_fifo_empty(empty), .rdreq(rdreq_a),
    .ready_in(ready_in), .data_out(data_a), .valid_out(valid_a), .frame_done(fd_a),
    .overflow(ovf_a));

  featuremap_accum_stream #(.DATA_WIDTH(DW), .NUM_CH(NCH), .BIAS(32'h0), .RELU_EN(1'b0),
                            .WIDTH(4), .HEIGHT(2)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .data_fifo_empty(empty), .rdreq(rdreq_b),
    .ready_in(ready_in), .data_out(data_b), .valid_out(valid_b), .frame_done(fd_b),
    .overflow(ovf_b));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_all(input logic [31:0] v, input logic ramp);
    for (int c = 0; c < NCH; c++) data_in[c*DW +: DW] = ramp ? 32'(v * (c + 1)) : v;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    empty = '1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v);
    int lat;
    @(negedge clk);
    set_all(v.ch, v.ramp);
    empty = '0;
    ready_in = 1'b1;
    #1 chk("vec_rdreq", {63'd0, rdreq_a}, 64'd1);
    @(negedge clk);
    empty = '1;
    lat = 0;
    while (!valid_a && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("vec_latency", 64'(lat), 64'd5);
    chk("vec_data_a", {32'd0, data_a}, {32'd0, v.exp_a});
    chk("vec_data_b", {32'd0, data_b}, {32'd0, v.exp_b});
    chk("vec_ovf_a", {63'd0, ovf_a}, {63'd0, v.ovf});
    chk("vec_ovf_b", {63'd0, ovf_b}, {63'd0, v.ovf});
    @(negedge clk);
  endtask

  initial begin
    int p, got, cyc, hs, extra;
    logic [31:0] prev;
    logic stalled_prev, fd_exp;

    tbl[0] = '{32'h00010000, 1'b0, 32'h00108000, 32'h00100000, 1'b0};
    tbl[1] = '{32'hFFFF0000, 1'b0, 32'h00000000, 32'hFFF00000, 1'b0};
    tbl[2] = '{32'h00000001, 1'b1, 32'h00008088, 32'h00000088, 1'b0};
    tbl[3] = '{32'h00010000, 1'b1, 32'h00888000, 32'h00880000, 1'b0};
    tbl[4] = '{32'hFFFFFFFF, 1'b0, 32'h00007FF0, 32'hFFFFFFF0, 1'b0};
    tbl[5] = '{32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1};
    tbl[6] = '{32'h80000000, 1'b0, 32'h00000000, 32'h80000000, 1'b1};
    tbl[7] = '{32'h00010000, 1'b0, 32'h00108000, 32'h00100000, 1'b1};

    rst = 1'b0;
    empty = '1;
    ready_in = 1'b1;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdreq", {63'd0, rdreq_a}, 64'd0);
    chk("rst_valid", {63'd0, valid_a}, 64'd0);
    chk("rst_data", {32'd0, data_a}, 64'd0);
    chk("rst_ovf", {63'd0, ovf_a}, 64'd0);
    chk("rst_frame_done", {63'd0, fd_a}, 64'd0);

    // Release with FIFOs already non-empty: no read until the next rising edge.
    empty = '0;
    #1 rst = 1'b1;
    #1 chk("rdreq_before_edge", {63'd0, rdreq_a}, 64'd0);
    @(negedge clk);
    chk("rdreq_after_edge", {63'd0, rdreq_a}, 64'd1);
    empty = '1;
    pulse_reset();

    for (int i = 0; i < 8; i++) apply_vec(tbl[i]);

    // Ten ascending pixels with a three-cycle downstream stall.
    pulse_reset();
    p = 0; got = 0; cyc = 0; prev = '0; stalled_prev = 1'b0;
    while (got < 10 && cyc < 80) begin
      @(negedge clk);
      set_all(32'(p + 1), 1'b0);
      empty = (p < 10) ? '0 : '1;
      ready_in = !(cyc >= 8 && cyc < 11);
      #1;
      if (valid_b && !ready_in) begin
        chk("stall_rdreq", {63'd0, rdreq_a}, 64'd0);
        if (stalled_prev) chk("stall_stable", {32'd0, data_b}, {32'd0, prev});
      end
      stalled_prev = valid_b && !ready_in;
      if (rdreq_a) p++;
      if (valid_b && ready_in) begin
        chk("stream_data", {32'd0, data_b}, 64'(16 * (got + 1)));
        got++;
      end
      prev = data_b;
      cyc++;
    end
    chk("stream_count", 64'(got), 64'd10);
    chk("stream_reads", 64'(p), 64'd10);
    @(negedge clk);
    empty = '1;
    ready_in = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid_b) extra++;
    end
    chk("stream_no_dup", 64'(extra), 64'd0);

    // 4x2 frame: pulse after handshakes 8 and 16, proving the wrap to column 0 row 0.
    pulse_reset();
    hs = 0; cyc = 0; fd_exp = 1'b0;
    while (hs < 16 && cyc < 60) begin
      @(negedge clk);
      set_all(32'h1, 1'b0);
      empty = '0;
      ready_in = 1'b1;
      #1;
      chk("frame_done_a", {63'd0, fd_a}, {63'd0, fd_exp});
      fd_exp = 1'b0;
      if (valid_a && ready_in) begin
        hs++;
        if (hs == 8 || hs == 16) fd_exp = 1'b1;
      end
      cyc++;
    end
    empty = '1;
    @(negedge clk);
    chk("frame_done_last_a", {63'd0, fd_a}, {63'd0, fd_exp});
    chk("frame_done_last_b", {63'd0, fd_b}, {63'd0, fd_exp});
    @(negedge clk);
    chk("frame_done_single", {63'd0, fd_a}, 64'd0);

    // Reset with pixels in flight and overflow set.
    pulse_reset();
    apply_vec(tbl[5]);
    @(negedge clk);
    set_all(32'h00020000, 1'b0);
    empty = '0;
    repeat (3) @(negedge clk);
    empty = '1;
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, valid_a}, 64'd0);
    chk("midrst_ovf", {63'd0, ovf_a}, 64'd0);
    chk("midrst_data", {32'd0, data_a}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_a || valid_b) extra++;
    end
    chk("midrst_no_stale", 64'(extra), 64'd0);
    apply_vec(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
